// File: rtl/win_banner_scan_pkg.sv
// Shared constants for the WIN banner scan path: ROM color codes, blink state codes, pipeline flags.
package win_banner_scan_pkg;

  localparam logic [11:0] NullColor    = 12'h000;
  localparam logic [11:0] WinColor     = 12'hFD0;
  localparam logic [11:0] WarningColor = 12'hF00;

  localparam logic [1:0] BannerIdle = 2'd0;
  localparam logic [1:0] BannerShow = 2'd1;
  localparam logic [1:0] BannerHide = 2'd2;

  typedef struct packed {
    logic        win;
    logic        vis;
    logic [11:0] bg;
  } pipe_flags_t;

endpackage

// File: rtl/win_banner_scan_if.sv
// Scan-side, ROM-side and pixel-side signals of the WIN banner block.
interface win_banner_scan_if;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        video_on;
  logic        enable;
  logic [11:0] bg_color;
  logic [5:0]  rom_x;
  logic [2:0]  rom_y;
  logic [11:0] rom_color;
  logic [11:0] pixel_out;
  logic [1:0]  banner_state;

  modport master (
    output h_cnt, v_cnt, video_on, enable, bg_color, rom_color,
    input  rom_x, rom_y, pixel_out, banner_state
  );

  modport slave (
    input  h_cnt, v_cnt, video_on, enable, bg_color, rom_color,
    output rom_x, rom_y, pixel_out, banner_state
  );
endinterface

// File: rtl/win_banner_scan_blink_fsm.sv
// Banner blink controller: IDLE until enabled, then alternates SHOW/HIDE every BLINK_FRAMES frames.
module win_banner_scan_blink_fsm
  import win_banner_scan_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_i,
  input  logic       frame_tick_i,
  output logic       show_o,
  output logic [1:0] state_o
);

  localparam int unsigned CntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BLINK_FRAMES - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable_i) begin
      state_d = BannerIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        // The tick coinciding with the enable edge is deliberately not counted.
        BannerIdle: begin
          state_d = BannerShow;
          cnt_d   = '0;
        end
        BannerShow, BannerHide: begin
          if (frame_tick_i) begin
            if (cnt_q == CntLast) begin
              state_d = (state_q == BannerShow) ? BannerHide : BannerShow;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = BannerIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BannerIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign show_o  = (state_q == BannerShow);
  assign state_o = state_q;

endmodule

// File: rtl/win_banner_scan.sv
// WIN banner scan path: scan counters -> glyph ROM address, 3-cycle composite over background.
// Optional BANNER_BORDER_EN draws a 1-pixel WinColor frame around the window while shown.
module win_banner_scan
  import win_banner_scan_pkg::*;
#(
  parameter int unsigned X0           = 236,
  parameter int unsigned Y0           = 208,
  parameter int unsigned SCALE_LOG2   = 3,
  parameter int unsigned COLS         = 21,
  parameter int unsigned ROWS         = 8,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input logic              clk,
  input logic              rst,
  win_banner_scan_if.slave bus
);

  localparam logic [10:0] XLo = 11'(X0);
  localparam logic [10:0] XHi = 11'(X0 + (COLS << SCALE_LOG2));
  localparam logic [10:0] YLo = 11'(Y0);
  localparam logic [10:0] YHi = 11'(Y0 + (ROWS << SCALE_LOG2));

  logic [10:0] h_ext, v_ext, dx, dy;
  logic        in_win, frame_tick, show;
  logic [5:0]  rom_x_q, rom_x_d;
  logic [2:0]  rom_y_q, rom_y_d;
  logic [11:0] pixel_q, pixel_d;
  pipe_flags_t s1_q, s1_d, s2_q;

  assign h_ext      = {1'b0, bus.h_cnt};
  assign v_ext      = {1'b0, bus.v_cnt};
  assign in_win     = bus.video_on && (h_ext >= XLo) && (h_ext < XHi)
                      && (v_ext >= YLo) && (v_ext < YHi);
  assign dx         = h_ext - XLo;
  assign dy         = v_ext - YLo;
  assign frame_tick = (bus.h_cnt == 10'd0) && (bus.v_cnt == 10'd0);

  // Outside the window address the blank column so the ROM never flags an out-of-range read.
  assign rom_x_d = in_win ? 6'(dx >> SCALE_LOG2) : '0;
  assign rom_y_d = in_win ? 3'(dy >> SCALE_LOG2) : '0;
  assign s1_d    = '{win: in_win, vis: bus.video_on, bg: bus.bg_color};

`ifdef BANNER_BORDER_EN
  logic border_d, border_d1_q, border_d2_q;
  assign border_d = in_win && ((h_ext == XLo) || (h_ext == XHi - 11'd1)
                               || (v_ext == YLo) || (v_ext == YHi - 11'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      border_d1_q <= 1'b0;
      border_d2_q <= 1'b0;
    end else begin
      border_d1_q <= border_d;
      border_d2_q <= border_d1_q;
    end
  end
`endif

  always_comb begin
    pixel_d = s2_q.bg;
    if (!s2_q.vis) begin
      pixel_d = 12'h000;
`ifdef BANNER_BORDER_EN
    end else if (show && border_d2_q) begin
      pixel_d = WinColor;
`endif
    end else if (s2_q.win && show && (bus.rom_color != NullColor)) begin
      pixel_d = bus.rom_color;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_x_q <= '0;
      rom_y_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      pixel_q <= 12'h000;
    end else begin
      rom_x_q <= rom_x_d;
      rom_y_q <= rom_y_d;
      s1_q    <= s1_d;
      s2_q    <= s1_q;
      pixel_q <= pixel_d;
    end
  end

  win_banner_scan_blink_fsm #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink_fsm (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (bus.enable),
    .frame_tick_i (frame_tick),
    .show_o       (show),
    .state_o      (bus.banner_state)
  );

  assign bus.rom_x     = rom_x_q;
  assign bus.rom_y     = rom_y_q;
  assign bus.pixel_out = pixel_q;

endmodule

// File: tb/tb_win_banner_scan.sv
// Scoreboard bench for win_banner_scan: random scan stimulus, glyph ROM model, blink model.
module tb_win_banner_scan;
  import win_banner_scan_pkg::*;

  localparam int unsigned Bf   = 2;
  localparam int          NCyc = 4000;

  typedef struct {
    int          idx;
    logic        vis;
    logic        win;
    logic        border;
    logic [5:0]  rx;
    logic [2:0]  ry;
    logic [11:0] bg;
  } item_t;

  logic clk = 1'b1;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_k = -1;
  item_t q[$];
  logic [1:0] st_hist[NCyc];

  // Bench-side model state for the blink behaviour: ticks seen since the banner was enabled.
  bit running = 0;
  int n_ticks = 0;

  win_banner_scan_if bus ();

  win_banner_scan #(
    .BLINK_FRAMES (Bf)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] glyph(input logic [5:0] x, input logic [2:0] y);
    if (x >= 6'd21) return WarningColor;
    if (x == 6'd0) return NullColor;
    if ((32'(x) + 32'(y)) % 3 == 0) return NullColor;
    return x[0] ? WinColor : 12'h0F0;
  endfunction

  // Registered glyph ROM: one-cycle read latency.
  always @(posedge clk) bus.rom_color <= glyph(bus.rom_x, bus.rom_y);

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_pixel(input item_t it, input logic show);
    if (!it.vis) return 12'h000;
`ifdef BANNER_BORDER_EN
    if (show && it.border) return WinColor;
`endif
    if (it.win && show && glyph(it.rx, it.ry) != NullColor) return glyph(it.rx, it.ry);
    return it.bg;
  endfunction

  task automatic drive(input int h, input int v, input bit vis, input bit en, input bit r,
                       input logic [11:0] bg);
    item_t it;
    int k;
    logic [1:0] nxt;
    @(negedge clk);
    k = cyc;
    bus.h_cnt    = 10'(h);
    bus.v_cnt    = 10'(v);
    bus.video_on = vis;
    bus.enable   = en;
    bus.bg_color = bg;
    rst          = r;
    it.idx    = k;
    it.vis    = vis && !r;
    it.win    = it.vis && h >= 236 && h < 236 + 21 * 8 && v >= 208 && v < 208 + 8 * 8;
    it.rx     = it.win ? 6'((h - 236) / 8) : 6'd0;
    it.ry     = it.win ? 3'((v - 208) / 8) : 3'd0;
    it.border = it.win && (h == 236 || h == 403 || v == 208 || v == 271);
    it.bg     = bg;
    // A reset flushes the two scan positions still in flight as blank pixels.
    if (r) foreach (q[i]) if (q[i].idx >= k - 2) q[i].vis = 1'b0;
    q.push_back(it);
    if (r || !en) begin
      running = 0;
      n_ticks = 0;
      nxt = BannerIdle;
    end else if (!running) begin
      running = 1;
      n_ticks = 0;
      nxt = BannerShow;
    end else begin
      if (h == 0 && v == 0) n_ticks++;
      nxt = ((n_ticks / Bf) % 2 == 0) ? BannerShow : BannerHide;
    end
    if (k + 1 < NCyc) st_hist[k + 1] = nxt;
    last_k = k;
  endtask

  initial begin : monitor
    item_t it;
    int j;
    forever begin
      @(posedge clk);
      #1;
      j = cyc;
      if (q.size() > 0 && q[$].idx == j - 1) begin
        check("rom_x", int'(bus.rom_x), int'(q[$].rx));
        check("rom_y", int'(bus.rom_y), int'(q[$].ry));
      end
      if (j >= 1 && j - 1 <= last_k && j < NCyc)
        check("banner_state", int'(bus.banner_state), int'(st_hist[j]));
      while (q.size() > 0 && q[0].idx < j - 3) begin
        it = q.pop_front();
        check("pixel_skipped", it.idx, j - 3);
      end
      if (q.size() > 0 && q[0].idx == j - 3) begin
        it = q.pop_front();
        check("pixel_out", int'(bus.pixel_out),
              int'(exp_pixel(it, st_hist[it.idx + 2] == BannerShow)));
      end
    end
  end

  initial begin : stimulus
    bit en;
    bus.h_cnt = '0;
    bus.v_cnt = '0;
    bus.video_on = 1'b0;
    bus.enable = 1'b0;
    bus.bg_color = '0;
    repeat (3) drive(5, 5, 1, 0, 1, 12'h000);
    // Address mapping corners and out-of-window cases with banner idle.
    drive(236, 208, 1, 0, 0, 12'h00F);
    drive(244, 208, 1, 0, 0, 12'h00F);
    drive(403, 271, 1, 0, 0, 12'h00F);
    drive(235, 210, 1, 0, 0, 12'h00F);
    drive(404, 210, 1, 0, 0, 12'h00F);
    drive(300, 207, 1, 0, 0, 12'h00F);
    drive(300, 272, 1, 0, 0, 12'h00F);
    // Banner shown over glyph pixels, including video_on low inside the window.
    for (int i = 0; i < 12; i++) drive(244 + 8 * i, 216, 1, 1, 0, 12'h00F);
    drive(260, 220, 0, 1, 0, 12'h00F);
    // Blink: several frame ticks with enable held.
    for (int i = 0; i < 24; i++)
      if (i % 3 == 0) drive(0, 0, 1, 1, 0, 12'h123);
      else drive(252 + i, 230, 1, 1, 0, 12'h123);
    // Drop enable, then reassert it together with a frame tick.
    drive(260, 216, 1, 0, 0, 12'h0A0);
    drive(0, 0, 1, 1, 0, 12'h0A0);
    for (int i = 0; i < 6; i++) drive(i % 2 == 0 ? 0 : 268, i % 2 == 0 ? 0 : 216, 1, 1, 0, 12'h0A0);
    // Mid-frame reset while shown.
    drive(268, 224, 1, 1, 1, 12'h0A0);
    for (int i = 0; i < 5; i++) drive(236, 230 + i, 1, 1, 0, 12'h0A0);
    en = 1;
    for (int i = 0; i < 3000; i++) begin
      int mode, h, v;
      mode = int'($urandom_range(0, 9));
      if (mode == 0) begin
        h = 0; v = 0;
      end else if (mode <= 5) begin
        h = int'($urandom_range(236, 403)); v = int'($urandom_range(208, 271));
      end else if (mode == 6) begin
        h = int'($urandom_range(0, 1)) ? 235 + 169 * int'($urandom_range(0, 1))
                                       : 236 + 167 * int'($urandom_range(0, 1));
        v = int'($urandom_range(206, 273));
      end else begin
        h = int'($urandom_range(0, 799)); v = int'($urandom_range(0, 524));
      end
      if ($urandom_range(0, 49) == 0) en = !en;
      drive(h, v, $urandom_range(0, 9) != 0, en, $urandom_range(0, 299) == 0,
            12'($urandom));
    end
    repeat (4) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
